// File: rtl/sd_secbuf_pkg.sv
// rtl/sd_secbuf_pkg.sv - shared constants, pointer type and transfer mode for the SD sector buffer
package sd_secbuf_pkg;
    localparam int SECT_BYTES = 512;
    localparam int PTR_W = $clog2(SECT_BYTES) + 1;
    localparam logic [31:0] BKHD_SIG = 32'h424B4844;
    localparam logic [7:0] BKHD_VER = 8'd1;

    typedef logic [PTR_W-1:0] sec_ptr_t;
    typedef enum logic [1:0] {IDLE, XFER_DATA, XFER_CONF} mode_t;

    function automatic logic hdr_match(input logic [31:0] sig, input logic [7:0] ver);
        return (sig == BKHD_SIG) && (ver == BKHD_VER);
    endfunction
endpackage

// File: rtl/sd_strobe_sync.sv
// rtl/sd_strobe_sync.sv - two-flop synchroniser with rising/falling edge detect
module sd_strobe_sync (
    input  logic clk_ram,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk_ram) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], d_i};
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/sd_sector_buf.sv
// rtl/sd_sector_buf.sv - SD-side 512-byte sector buffer with BKHD header capture
// SD_SECBUF_CHECKSUM_EN enables the running byte checksum output.
module sd_sector_buf
    import sd_secbuf_pkg::*;
(
    input  logic        clk_ram,
    input  logic        reset,
    input  logic        conf,
    input  logic        sd_ack,
    input  logic [7:0]  sd_dout,
    input  logic        sd_dout_strobe,
    output logic [7:0]  sd_din,
    input  logic        sd_din_strobe,
    input  logic [7:0]  host_addr,
    input  logic [15:0] host_wdata,
    input  logic        host_we,
    output logic [15:0] host_rdata,
    input  logic [6:0]  hdr_addr,
    output logic [31:0] hdr_q,
    output logic        busy,
    output logic        sec_done,
    output logic        short_err,
    output logic        overrun,
    output logic        hdr_valid,
    output logic [15:0] checksum
);
    logic dout_rise, dout_fall, din_rise, din_fall, ack_rise, ack_fall;
    logic unused_fall;

    sd_strobe_sync u_dout (.clk_ram(clk_ram), .reset(reset), .d_i(sd_dout_strobe), .rise_o(dout_rise), .fall_o(dout_fall));
    sd_strobe_sync u_din  (.clk_ram(clk_ram), .reset(reset), .d_i(sd_din_strobe),  .rise_o(din_rise),  .fall_o(din_fall));
    sd_strobe_sync u_ack  (.clk_ram(clk_ram), .reset(reset), .d_i(sd_ack),         .rise_o(ack_rise),  .fall_o(ack_fall));

    assign unused_fall = dout_fall ^ din_fall;

    mode_t mode_q, mode_d;
    logic  busy_w, mode_conf;

    always_ff @(posedge clk_ram) begin
        if (reset) mode_q <= IDLE;
        else       mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (ack_rise)      mode_d = conf ? XFER_CONF : XFER_DATA;
        else if (ack_fall) mode_d = IDLE;
    end

    always_comb begin
        busy_w    = (mode_q != IDLE);
        mode_conf = (mode_q == XFER_CONF);
    end

    sec_ptr_t ptr_q, ptr_d;
    logic ptr_full, dout_acc, din_acc, proto_err, data_wr, conf_wr;

    // dout wins a same-cycle collision; the lost din edge is reported as overrun
    assign ptr_full  = (ptr_q == sec_ptr_t'(SECT_BYTES));
    assign dout_acc  = busy_w && dout_rise && !ptr_full;
    assign din_acc   = busy_w && din_rise && !dout_rise && !ptr_full;
    assign proto_err = busy_w && (((dout_rise || din_rise) && ptr_full) || (dout_rise && din_rise));
    assign data_wr   = dout_acc && !mode_conf;
    assign conf_wr   = dout_acc && mode_conf;

    always_comb begin
        ptr_d = ptr_q;
        if (ack_rise)               ptr_d = '0;
        else if (dout_acc || din_acc) ptr_d = ptr_q + 1'b1;
    end

    logic sec_done_q, short_err_q, overrun_q, hdr_eval_q, hdr_valid_q;
    logic [7:0] hdr_b_q [5];

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            ptr_q       <= '0;
            sec_done_q  <= 1'b0;
            short_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            hdr_eval_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            sec_done_q <= busy_w && ack_fall && ptr_full;
            hdr_eval_q <= mode_conf && ack_fall;
            if (ack_rise) begin
                short_err_q <= 1'b0;
                overrun_q   <= 1'b0;
                if (conf) hdr_valid_q <= 1'b0;
            end else begin
                if (busy_w && ack_fall && !ptr_full) short_err_q <= 1'b1;
                if (proto_err)                      overrun_q   <= 1'b1;
                if (hdr_eval_q)
                    hdr_valid_q <= hdr_match({hdr_b_q[0], hdr_b_q[1], hdr_b_q[2], hdr_b_q[3]}, hdr_b_q[4]);
            end
        end
    end

    logic [15:0] ram_q [256];
    logic [31:0] tbl_q [128];
    logic [15:0] host_rdata_q;
    logic [31:0] hdr_q_q;
    logic [7:0]  sd_din_q;

    always_ff @(posedge clk_ram) begin
        if (data_wr) begin
            if (ptr_q[0]) ram_q[ptr_q[8:1]][15:8] <= sd_dout;
            else          ram_q[ptr_q[8:1]][7:0]  <= sd_dout;
        end else if (!busy_w && host_we) begin
            ram_q[host_addr] <= host_wdata;
        end
        host_rdata_q <= ram_q[host_addr];
    end

    always_ff @(posedge clk_ram) begin
        if (conf_wr) begin
            tbl_q[ptr_q[8:2]][{ptr_q[1:0], 3'b000} +: 8] <= sd_dout;
            if (ptr_q < sec_ptr_t'(5)) hdr_b_q[ptr_q[2:0]] <= sd_dout;
        end
        hdr_q_q <= tbl_q[hdr_addr];
    end

    // Byte at the pointer is re-fetched every cycle so sd_din is ready before each din strobe
    always_ff @(posedge clk_ram) begin
        if (reset)         sd_din_q <= 8'h00;
        else if (ptr_q[0]) sd_din_q <= ram_q[ptr_q[8:1]][15:8];
        else               sd_din_q <= ram_q[ptr_q[8:1]][7:0];
    end

`ifdef SD_SECBUF_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk_ram) begin
        if (reset || ack_rise) csum_q <= 16'h0000;
        else if (dout_acc)     csum_q <= csum_q + {8'h00, sd_dout};
        else if (din_acc)      csum_q <= csum_q + {8'h00, sd_din_q};
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign sd_din     = sd_din_q;
    assign host_rdata = host_rdata_q;
    assign hdr_q      = hdr_q_q;
    assign busy       = busy_w;
    assign sec_done   = sec_done_q;
    assign short_err  = short_err_q;
    assign overrun    = overrun_q;
    assign hdr_valid  = hdr_valid_q;
endmodule

// File: tb/tb_sd_sector_buf.sv
// tb/tb_sd_sector_buf.sv - randomized self-checking bench for sd_sector_buf against a byte-array model
module tb_sd_sector_buf;
    logic        clk_ram = 1'b0;
    logic        reset = 1'b1;
    logic        conf = 1'b0;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_dout = 8'h00;
    logic        sd_dout_strobe = 1'b0;
    logic        sd_din_strobe = 1'b0;
    logic [7:0]  host_addr = 8'h00;
    logic [15:0] host_wdata = 16'h0000;
    logic        host_we = 1'b0;
    logic [6:0]  hdr_addr = 7'h00;
    logic [7:0]  sd_din;
    logic [15:0] host_rdata;
    logic [31:0] hdr_q;
    logic        busy, sec_done, short_err, overrun, hdr_valid;
    logic [15:0] checksum;

    sd_sector_buf dut (
        .clk_ram(clk_ram), .reset(reset), .conf(conf), .sd_ack(sd_ack),
        .sd_dout(sd_dout), .sd_dout_strobe(sd_dout_strobe), .sd_din(sd_din),
        .sd_din_strobe(sd_din_strobe), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_we(host_we), .host_rdata(host_rdata), .hdr_addr(hdr_addr), .hdr_q(hdr_q),
        .busy(busy), .sec_done(sec_done), .short_err(short_err), .overrun(overrun),
        .hdr_valid(hdr_valid), .checksum(checksum)
    );

    always #5 clk_ram = ~clk_ram;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [7:0] ram_b [512];
    logic [7:0] sec [512];

    always @(negedge clk_ram) if (sec_done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [15:0] model_word(input int k);
        return {ram_b[2*k+1], ram_b[2*k]};
    endfunction

    function automatic logic [15:0] exp_csum(input logic [15:0] sum);
`ifdef SD_SECBUF_CHECKSUM_EN
        return sum;
`else
        return 16'h0000 & sum;
`endif
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_ram);
    endtask

    task automatic ack_up(input logic c);
        conf = c; sd_ack = 1'b1; tick(6);
    endtask

    task automatic ack_down();
        sd_ack = 1'b0; tick(6);
    endtask

    task automatic send_byte(input logic [7:0] b);
        sd_dout = b; sd_dout_strobe = 1'b1; tick(2); sd_dout_strobe = 1'b0; tick(4);
    endtask

    task automatic pull_byte();
        sd_din_strobe = 1'b1; tick(2); sd_din_strobe = 1'b0; tick(4);
    endtask

    task automatic send_range(input int first, input int last, input logic cfg);
        for (int i = first; i <= last; i++) begin
            send_byte(sec[i]);
            if (!cfg) ram_b[i] = sec[i];
        end
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1; tick(1); host_we = 1'b0;
    endtask

    task automatic read_word(input logic [7:0] a, output logic [15:0] d);
        host_addr = a; tick(1); d = host_rdata;
    endtask

    task automatic read_hdr(input logic [6:0] a, output logic [31:0] q);
        hdr_addr = a; tick(1); q = hdr_q;
    endtask

    task automatic randomize_sec();
        for (int i = 0; i < 512; i++) sec[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(3);
        vectors++; if (sd_din !== 8'h00) begin miscompares++; $display("FAIL reset_sd_din: got %h want 00", sd_din); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (sec_done !== 1'b0) begin miscompares++; $display("FAIL reset_sec_done: got %b want 0", sec_done); end
        vectors++; if (short_err !== 1'b0) begin miscompares++; $display("FAIL reset_short_err: got %b want 0", short_err); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        vectors++; if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hdr_valid: got %b want 0", hdr_valid); end
        vectors++; if (checksum !== 16'h0000) begin miscompares++; $display("FAIL reset_checksum: got %h want 0000", checksum); end
        reset = 1'b0; tick(3);
    endtask

    task automatic test_data_read();
        int d0;
        logic [15:0] w, sum;
        sum = 16'h0;
        for (int i = 0; i < 512; i++) begin sec[i] = 8'(i); sum = sum + 16'(sec[i]); end
        d0 = done_cnt;
        ack_up(1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy: got %b want 1", busy); end
        send_range(0, 511, 1'b0);
        ack_down();
        vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL read_sec_done: got %0d pulses want 1", done_cnt - d0); end
        vectors++; if (short_err !== 1'b0) begin miscompares++; $display("FAIL read_short_err: got %b want 0", short_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_end: got %b want 0", busy); end
        read_word(8'd0, w);
        vectors++; if (w !== 16'h0100) begin miscompares++; $display("FAIL read_word0: got %h want 0100", w); end
        read_word(8'd255, w);
        vectors++; if (w !== 16'hFFFE) begin miscompares++; $display("FAIL read_word255: got %h want fffe", w); end
        vectors++; if (checksum !== exp_csum(sum)) begin miscompares++; $display("FAIL read_checksum: got %h want %h", checksum, exp_csum(sum)); end
    endtask

    task automatic test_data_write();
        int d0;
        logic [7:0] exp_b;
        logic [15:0] sum;
        for (int k = 0; k < 256; k++) begin
            host_write(8'(k), {8'hA5, 8'(k)});
            ram_b[2*k] = 8'(k); ram_b[2*k+1] = 8'hA5;
        end
        d0 = done_cnt;
        sum = 16'h0;
        ack_up(1'b0);
        for (int i = 0; i < 512; i++) begin
            exp_b = i[0] ? 8'hA5 : 8'(i / 2);
            sum = sum + 16'(exp_b);
            vectors++; if (sd_din !== exp_b) begin miscompares++; $display("FAIL write_sd_din[%0d]: got %h want %h", i, sd_din, exp_b); end
            pull_byte();
        end
        ack_down();
        vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL write_sec_done: got %0d pulses want 1", done_cnt - d0); end
        vectors++; if (checksum !== exp_csum(sum)) begin miscompares++; $display("FAIL write_checksum: got %h want %h", checksum, exp_csum(sum)); end
    endtask

    task automatic test_random_xfer();
        int d0;
        int k;
        logic [15:0] w;
        randomize_sec();
        d0 = done_cnt;
        ack_up(1'b0);
        send_range(0, 511, 1'b0);
        ack_down();
        vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL rand_sec_done: got %0d pulses want 1", done_cnt - d0); end
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 255);
            read_word(8'(k), w);
            vectors++; if (w !== model_word(k)) begin miscompares++; $display("FAIL rand_word[%0d]: got %h want %h", k, w, model_word(k)); end
        end
        ack_up(1'b0);
        for (int i = 0; i < 512; i++) begin
            vectors++; if (sd_din !== ram_b[i]) begin miscompares++; $display("FAIL rand_sd_din[%0d]: got %h want %h", i, sd_din, ram_b[i]); end
            pull_byte();
        end
        ack_down();
    endtask

    task automatic test_config(input logic [7:0] ver, input logic exp_valid);
        int j;
        logic [31:0] q, exp_q;
        logic [15:0] w;
        randomize_sec();
        sec[0] = 8'h42; sec[1] = 8'h4B; sec[2] = 8'h48; sec[3] = 8'h44; sec[4] = ver;
        sec[8] = 8'h78; sec[9] = 8'h56; sec[10] = 8'h34; sec[11] = 8'h12;
        ack_up(1'b1);
        vectors++; if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL conf_hdr_cleared: got %b want 0", hdr_valid); end
        send_range(0, 11, 1'b1);
        read_hdr(7'd2, q);
        vectors++; if (q !== 32'h12345678) begin miscompares++; $display("FAIL conf_partial_tbl: got %h want 12345678", q); end
        send_range(12, 511, 1'b1);
        ack_down();
        vectors++; if (hdr_valid !== exp_valid) begin miscompares++; $display("FAIL conf_hdr_valid: got %b want %b", hdr_valid, exp_valid); end
        read_hdr(7'd2, q);
        vectors++; if (q !== 32'h12345678) begin miscompares++; $display("FAIL conf_tbl2: got %h want 12345678", q); end
        for (int n = 0; n < 8; n++) begin
            j = $urandom_range(0, 127);
            exp_q = {sec[4*j+3], sec[4*j+2], sec[4*j+1], sec[4*j]};
            read_hdr(7'(j), q);
            vectors++; if (q !== exp_q) begin miscompares++; $display("FAIL conf_tbl[%0d]: got %h want %h", j, q, exp_q); end
        end
        read_word(8'd0, w);
        vectors++; if (w !== model_word(0)) begin miscompares++; $display("FAIL conf_ram_untouched: got %h want %h", w, model_word(0)); end
    endtask

    task automatic test_short();
        int d0;
        randomize_sec();
        d0 = done_cnt;
        ack_up(1'b0);
        send_range(0, 99, 1'b0);
        ack_down();
        vectors++; if (short_err !== 1'b1) begin miscompares++; $display("FAIL short_err: got %b want 1", short_err); end
        vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL short_no_done: got %0d pulses want 0", done_cnt - d0); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL short_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        int d0;
        logic [15:0] w;
        randomize_sec();
        d0 = done_cnt;
        ack_up(1'b0);
        vectors++; if (short_err !== 1'b0) begin miscompares++; $display("FAIL ovr_short_cleared: got %b want 0", short_err); end
        send_range(0, 511, 1'b0);
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_early: got %b want 0", overrun); end
        send_byte(~sec[0]);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        ack_down();
        vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL ovr_sec_done: got %0d pulses want 1", done_cnt - d0); end
        read_word(8'd0, w);
        vectors++; if (w !== model_word(0)) begin miscompares++; $display("FAIL ovr_word0: got %h want %h", w, model_word(0)); end
    endtask

    task automatic test_collision();
        int d0;
        logic [15:0] w;
        randomize_sec();
        d0 = done_cnt;
        ack_up(1'b0);
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL coll_ovr_cleared: got %b want 0", overrun); end
        sd_dout = sec[0]; sd_dout_strobe = 1'b1; sd_din_strobe = 1'b1; tick(2);
        sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0; tick(4);
        ram_b[0] = sec[0];
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL coll_overrun: got %b want 1", overrun); end
        send_range(1, 511, 1'b0);
        ack_down();
        vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL coll_sec_done: got %0d pulses want 1", done_cnt - d0); end
        vectors++; if (short_err !== 1'b0) begin miscompares++; $display("FAIL coll_short: got %b want 0", short_err); end
        read_word(8'd0, w);
        vectors++; if (w !== model_word(0)) begin miscompares++; $display("FAIL coll_word0: got %h want %h", w, model_word(0)); end
        read_word(8'd255, w);
        vectors++; if (w !== model_word(255)) begin miscompares++; $display("FAIL coll_word255: got %h want %h", w, model_word(255)); end
    endtask

    task automatic test_reset_mid();
        int d0;
        int k;
        logic [15:0] w;
        randomize_sec();
        d0 = done_cnt;
        ack_up(1'b0);
        send_range(0, 199, 1'b0);
        reset = 1'b1; tick(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
        sd_ack = 1'b0; tick(4);
        reset = 1'b0; tick(6);
        vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - d0); end
        vectors++; if (short_err !== 1'b0) begin miscompares++; $display("FAIL rmid_short: got %b want 0", short_err); end
        randomize_sec();
        ack_up(1'b0);
        send_range(0, 511, 1'b0);
        ack_down();
        vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL rmid_sec_done: got %0d pulses want 1", done_cnt - d0); end
        for (int n = 0; n < 8; n++) begin
            k = $urandom_range(0, 255);
            read_word(8'(k), w);
            vectors++; if (w !== model_word(k)) begin miscompares++; $display("FAIL rmid_word[%0d]: got %h want %h", k, w, model_word(k)); end
        end
    endtask

    task automatic test_host_blocked();
        logic [15:0] w;
        randomize_sec();
        ack_up(1'b0);
        send_range(0, 9, 1'b0);
        host_write(8'd0, 16'hDEAD);
        send_range(10, 511, 1'b0);
        ack_down();
        read_word(8'd0, w);
        vectors++; if (w !== model_word(0)) begin miscompares++; $display("FAIL blocked_word0: got %h want %h", w, model_word(0)); end
        host_write(8'd1, 16'h1234);
        ram_b[2] = 8'h34; ram_b[3] = 8'h12;
        read_word(8'd1, w);
        vectors++; if (w !== 16'h1234) begin miscompares++; $display("FAIL idle_host_write: got %h want 1234", w); end
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_data_write();
        test_random_xfer();
        test_config(8'h01, 1'b1);
        test_config(8'h02, 1'b0);
        test_short();
        test_overrun();
        test_collision();
        test_reset_mid();
        test_host_blocked();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
